retire_commit: RTL and testbench
================================

// Module: retire_commit
// PURPOSE
//  Retire stage directly downstream of the completion/ROB stage. Takes up to two in-order retired ROB entries
//  per cycle (slot a older than slot b). Returns superseded physical registers (rd_old) to the free list.
//  Buffers committed stores in an in-order queue and drains them to data memory over a valid/ready handshake.
// PARAMETERS
//  PREG_W    6   physical register tag width (matches robEntryStruct.rd/rd_old)
//  DATA_W    32  store address and data width
//  SQ_DEPTH  4   store commit queue entries; power of 2, >= 2
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  reset          in   1       synchronous, active-low reset
//  retire_instr_a in   struct  robEntryStruct, older retiring entry; live when .valid && .complete
//  retire_instr_b in   struct  robEntryStruct, younger retiring entry; same qualification
//  free_a_valid   out  1       slot a returns a physical register this cycle
//  free_a_preg    out  PREG_W  tag returned (rd_old of slot a)
//  free_b_valid   out  1       slot b returns a physical register
//  free_b_preg    out  PREG_W  tag returned (rd_old of slot b)
//  mem_req_valid  out  1       store queue head presented to memory
//  mem_req_addr   out  DATA_W  store address (ROB .result)
//  mem_req_data   out  DATA_W  store data (ROB .wr_data)
//  mem_req_ready  in   1       memory accepts head this cycle
//  sq_almost_full out  1       fewer than 2 free queue entries (retire-throttle hint)
//  sq_overflow    out  1       sticky: a store arrived with no free entry
//  retired_cnt    out  32      instructions retired (RETIRE_PERF_EN only)
//  sq_stall_cnt   out  32      cycles mem_req_valid && !mem_req_ready (RETIRE_PERF_EN only)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all outputs 0, queue empty (head=tail=count=0), counters 0, sq_overflow 0.
//    Reset mid-drain discards every queued store; mem_req_valid is 0 the cycle after reset is sampled.
//  - Slot live = valid && complete. Slot b is live only if slot a is live; a lone live b is ignored.
//  - Free list: live slot with control.RegWrite && rd_old != 0 -> free_x_valid=1, free_x_preg=rd_old,
//    registered, 1-cycle latency. p0 is never freed. Otherwise free_x_valid=0 and free_x_preg=0.
//  - Store enqueue: live slot with control.MemWrite pushes {result, wr_data} at tail.
//    Two stores in one cycle: a at tail, b at tail+1. Pointers wrap modulo SQ_DEPTH.
//  - Drain: mem_req_valid = (count != 0); addr/data = head entry, stable while valid && !ready.
//    Pop on mem_req_valid && mem_req_ready. A store enqueued at edge N is visible on mem_req_* from N+1.
//  - Push and pop in the same cycle: count += pushes - pop. Free space is evaluated after this cycle's pop,
//    so a full queue draining one entry still accepts one store.
//  - Overflow: push with no free entry drops that store (and slot b's store, if any), sets sq_overflow.
//    sq_overflow clears only on reset. Slot a takes the last free entry before slot b.
//  - sq_almost_full = (SQ_DEPTH - count) < 2, registered, from the post-update count.
//  - Loads (MemRead) and ALU ops need no action beyond freeing rd_old.
//    control.ALUOp, ALUSrc and MemtoReg are ignored.
//  - count width is $clog2(SQ_DEPTH)+1 so it can represent full.
// CONFIGURATION
//  RETIRE_PERF_EN defined:
//    retired_cnt += number of live slots each cycle (0/1/2), wraps at 2^32.
//    sq_stall_cnt += 1 each cycle with mem_req_valid && !mem_req_ready.
//  RETIRE_PERF_EN undefined: both counters absent from logic, ports tied to 0.
// TESTING
//  1. Reset low 2 cycles with live retire inputs and mem_req_ready=0
//     -> every output 0; after release, mem_req_valid stays 0.
//  2. a={valid,complete,RegWrite,rd_old=5}, b={valid,complete,RegWrite,rd_old=0}
//     -> next cycle free_a_valid=1, free_a_preg=5, free_b_valid=0.
//  3. a and b both stores (addr 0x100/data 0xA, addr 0x104/data 0xB), mem_req_ready=1
//     -> mem_req 0x100/0xA at N+1, then 0x104/0xB at N+2, then mem_req_valid=0.
//  4. mem_req_ready=0; issue 4 single stores, then a 5th
//     -> sq_almost_full=1 after the 3rd; 5th dropped; sq_overflow=1; queue drains 4 in order once ready=1.
//  5. Full queue, ready=1 and one new store in the same cycle
//     -> head pops, new store accepted, count stays 4, sq_overflow stays 0; pointers wrap correctly.
//  6. RETIRE_PERF_EN: 3 dual-retire cycles plus 2 stalled cycles -> retired_cnt=6, sq_stall_cnt=2;
//     undefined: both counters read 0.

Source files
------------

// File: rtl/retire_commit.sv
// retire_commit -- retire stage behind the completion/ROB stage.
//
// Purpose:
//   Takes up to two in-order retired ROB entries per cycle. Slot a is older
//   than slot b. Superseded physical registers (rd_old) are returned to the
//   free list. Committed stores go into an in-order queue, which drains to
//   data memory over a valid/ready handshake.
//
// Ports:
//   clk, reset                   clock; synchronous active-low reset
//   retire_instr_a/_b            robEntryStruct; a slot is live when .valid && .complete
//   free_{a,b}_valid/_preg       registered free-list returns (rd_old), 1-cycle latency
//   mem_req_valid/_addr/_data    store queue head; mem_req_ready accepts and pops it
//   sq_almost_full               fewer than 2 free queue entries (registered)
//   sq_overflow                  sticky; a store was dropped because the queue was full
//   retired_cnt, sq_stall_cnt    performance counters
//
// Configuration macro:
//   RETIRE_PERF_EN  enables retired_cnt / sq_stall_cnt. When it is undefined,
//                   both ports are tied to 0.
//
// The ROB entry types live at compilation-unit scope so that the producer stage
// and this stage share one definition. Their widths match the default
// PREG_W = 6 and DATA_W = 32.

typedef struct packed {
  logic       RegWrite;
  logic       MemtoReg;
  logic       MemRead;
  logic       MemWrite;
  logic       ALUSrc;
  logic [1:0] ALUOp;
} ctrlStruct;

typedef struct packed {
  logic        valid;
  logic        complete;
  logic [5:0]  rd;
  logic [5:0]  rd_old;
  logic [31:0] result;   // effective address for stores
  logic [31:0] wr_data;  // store data
  ctrlStruct   control;
} robEntryStruct;

module retire_commit #(
  parameter int PREG_W   = 6,
  parameter int DATA_W   = 32,
  parameter int SQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  robEntryStruct     retire_instr_a,
  input  robEntryStruct     retire_instr_b,
  output logic              free_a_valid,
  output logic [PREG_W-1:0] free_a_preg,
  output logic              free_b_valid,
  output logic [PREG_W-1:0] free_b_preg,
  output logic              mem_req_valid,
  output logic [DATA_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  output logic              sq_almost_full,
  output logic              sq_overflow,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       sq_stall_cnt
);

  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;  // wide enough to hold "full"

  // Queue state
  logic [DATA_W-1:0] r_sq_addr [SQ_DEPTH];
  logic [DATA_W-1:0] r_sq_data [SQ_DEPTH];
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count;

  // Registered outputs
  logic              r_free_a_valid, r_free_b_valid;
  logic [PREG_W-1:0] r_free_a_preg,  r_free_b_preg;
  logic              r_almost_full,  r_overflow;

  // Per-cycle decode
  logic             w_live_a, w_live_b;
  logic             w_push_a, w_push_b;
  logic             w_acc_a,  w_acc_b;
  logic             w_pop;
  logic [CNT_W-1:0] w_space, w_count_nxt;
  logic [PTR_W-1:0] w_tail_b;

  // b is only live behind a live a; a lone live b is ignored.
  assign w_live_a = retire_instr_a.valid & retire_instr_a.complete;
  assign w_live_b = w_live_a & retire_instr_b.valid & retire_instr_b.complete;
  assign w_push_a = w_live_a & retire_instr_a.control.MemWrite;
  assign w_push_b = w_live_b & retire_instr_b.control.MemWrite;
  assign w_pop    = (r_count != '0) & mem_req_ready;

  // Free space counts the slot this cycle's pop releases. That lets a full,
  // draining queue still take one store.
  assign w_space  = CNT_W'(SQ_DEPTH) - r_count + CNT_W'(w_pop);

  // a claims the last free entry first. If a's store is dropped, b's store is
  // dropped too, so that younger stores never get ahead of an older one.
  assign w_acc_a  = w_push_a & (w_space != '0);
  assign w_acc_b  = w_push_b & (w_push_a ? (w_acc_a & (w_space >= CNT_W'(2)))
                                         : (w_space != '0));
  assign w_tail_b = r_tail + PTR_W'(w_acc_a);

  assign w_count_nxt = r_count + CNT_W'(w_acc_a) + CNT_W'(w_acc_b) - CNT_W'(w_pop);

  // Queue storage has no reset. The head is gated by mem_req_valid, so stale
  // entries never reach the outputs.
  always_ff @(posedge clk) begin
    if (w_acc_a) begin
      r_sq_addr[r_tail] <= retire_instr_a.result;
      r_sq_data[r_tail] <= retire_instr_a.wr_data;
    end
    if (w_acc_b) begin
      r_sq_addr[w_tail_b] <= retire_instr_b.result;
      r_sq_data[w_tail_b] <= retire_instr_b.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_free_a_valid <= 1'b0;
      r_free_a_preg  <= '0;
      r_free_b_valid <= 1'b0;
      r_free_b_preg  <= '0;
      r_almost_full  <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      // p0 is hardwired and is never returned to the free list.
      r_free_a_valid <= 1'b0;
      r_free_a_preg  <= '0;
      r_free_b_valid <= 1'b0;
      r_free_b_preg  <= '0;
      if (w_live_a && retire_instr_a.control.RegWrite && retire_instr_a.rd_old != '0) begin
        r_free_a_valid <= 1'b1;
        r_free_a_preg  <= retire_instr_a.rd_old;
      end
      if (w_live_b && retire_instr_b.control.RegWrite && retire_instr_b.rd_old != '0) begin
        r_free_b_valid <= 1'b1;
        r_free_b_preg  <= retire_instr_b.rd_old;
      end

      if (w_pop)
        r_head <= r_head + PTR_W'(1);
      r_tail  <= r_tail + PTR_W'(w_acc_a) + PTR_W'(w_acc_b);
      r_count <= w_count_nxt;

      r_almost_full <= (CNT_W'(SQ_DEPTH) - w_count_nxt) < CNT_W'(2);
      if ((w_push_a && !w_acc_a) || (w_push_b && !w_acc_b))
        r_overflow <= 1'b1;
    end
  end

`ifdef RETIRE_PERF_EN
  logic [31:0] r_retired_cnt, r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      r_retired_cnt <= r_retired_cnt + 32'(w_live_a) + 32'(w_live_b);
      if (mem_req_valid && !mem_req_ready)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign retired_cnt  = r_retired_cnt;
  assign sq_stall_cnt = r_stall_cnt;
`else
  assign retired_cnt  = '0;
  assign sq_stall_cnt = '0;
`endif

  assign free_a_valid   = r_free_a_valid;
  assign free_a_preg    = r_free_a_preg;
  assign free_b_valid   = r_free_b_valid;
  assign free_b_preg    = r_free_b_preg;
  assign mem_req_valid  = (r_count != '0);
  assign mem_req_addr   = mem_req_valid ? r_sq_addr[r_head] : '0;
  assign mem_req_data   = mem_req_valid ? r_sq_data[r_head] : '0;
  assign sq_almost_full = r_almost_full;
  assign sq_overflow    = r_overflow;

  // Fields that retirement does not act on.
  logic w_unused;
  assign w_unused = &{1'b0, retire_instr_a.rd, retire_instr_b.rd,
                      retire_instr_a.control.MemtoReg, retire_instr_a.control.MemRead,
                      retire_instr_a.control.ALUSrc, retire_instr_a.control.ALUOp,
                      retire_instr_b.control.MemtoReg, retire_instr_b.control.MemRead,
                      retire_instr_b.control.ALUSrc, retire_instr_b.control.ALUOp};

endmodule

// File: tb/tb_retire_commit.sv
// Directed self-checking bench for retire_commit.
module tb_retire_commit;

  logic          clk;
  logic          reset;
  robEntryStruct ra, rb;
  logic          fav, fbv, mv, mrdy, af, ovf;
  logic [5:0]    fap, fbp;
  logic [31:0]   maddr, mdata, rcnt, scnt;

  int n_cmp = 0;
  int n_err = 0;

  retire_commit #(.PREG_W(6), .DATA_W(32), .SQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .retire_instr_a(ra), .retire_instr_b(rb),
    .free_a_valid(fav), .free_a_preg(fap),
    .free_b_valid(fbv), .free_b_preg(fbp),
    .mem_req_valid(mv), .mem_req_addr(maddr), .mem_req_data(mdata),
    .mem_req_ready(mrdy),
    .sq_almost_full(af), .sq_overflow(ovf),
    .retired_cnt(rcnt), .sq_stall_cnt(scnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic robEntryStruct mk(input logic v, input logic c, input logic rw,
                                       input logic mw, input logic [5:0] rdo,
                                       input logic [31:0] addr, input logic [31:0] data);
    robEntryStruct e;
    e = '0;
    e.valid = v; e.complete = c;
    e.control.RegWrite = rw; e.control.MemWrite = mw;
    e.rd_old = rdo; e.result = addr; e.wr_data = data;
    return e;
  endfunction

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; ra = '0; rb = '0; mrdy = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; mrdy = 1'b0;
    ra = mk(1, 1, 1, 1, 6'd3, 32'h50, 32'h1);
    rb = mk(1, 1, 1, 1, 6'd4, 32'h54, 32'h2);
    step(); step();
    n_cmp++; if ({fav, fbv, fap, fbp} !== 14'd0) begin n_err++; $display("FAIL reset_free got %b %b %0d %0d want 0", fav, fbv, fap, fbp); end
    n_cmp++; if ({mv, maddr, mdata} !== 65'd0) begin n_err++; $display("FAIL reset_mem got v=%b a=%h d=%h want 0", mv, maddr, mdata); end
    n_cmp++; if ({af, ovf, rcnt, scnt} !== 66'd0) begin n_err++; $display("FAIL reset_misc got af=%b ovf=%b r=%0d s=%0d want 0", af, ovf, rcnt, scnt); end
    ra = '0; rb = '0; reset = 1'b1;
    step();
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL reset_release1 mem_req_valid got %b want 0", mv); end
    step();
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL reset_release2 mem_req_valid got %b want 0", mv); end
  endtask

  task automatic test_free_list();
    ra = mk(1, 1, 1, 0, 6'd5, 0, 0);
    rb = mk(1, 1, 1, 0, 6'd0, 0, 0);
    step();
    n_cmp++; if (fav !== 1'b1 || fap !== 6'd5) begin n_err++; $display("FAIL free_a got v=%b p=%0d want 1/5", fav, fap); end
    n_cmp++; if (fbv !== 1'b0 || fbp !== 6'd0) begin n_err++; $display("FAIL free_b_p0 got v=%b p=%0d want 0/0", fbv, fbp); end
    // a is valid but not complete, so b must be ignored (no free, no store).
    ra = mk(1, 0, 1, 0, 6'd9, 0, 0);
    rb = mk(1, 1, 1, 1, 6'd7, 32'h77, 32'h7);
    step();
    n_cmp++; if (fav !== 1'b0 || fbv !== 1'b0) begin n_err++; $display("FAIL lone_b_free got a=%b b=%b want 0/0", fav, fbv); end
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL lone_b_store mem_req_valid got %b want 0", mv); end
    ra = '0; rb = '0;
    step();
    n_cmp++; if (fav !== 1'b0 || fap !== 6'd0) begin n_err++; $display("FAIL free_idle got v=%b p=%0d want 0/0", fav, fap); end
  endtask

  task automatic test_dual_store();
    mrdy = 1'b1;
    ra = mk(1, 1, 0, 1, 0, 32'h100, 32'hA);
    rb = mk(1, 1, 0, 1, 0, 32'h104, 32'hB);
    step();
    ra = '0; rb = '0;
    n_cmp++; if (mv !== 1'b1 || maddr !== 32'h100 || mdata !== 32'hA) begin n_err++; $display("FAIL dual_first got v=%b %h/%h want 1 100/a", mv, maddr, mdata); end
    step();
    n_cmp++; if (mv !== 1'b1 || maddr !== 32'h104 || mdata !== 32'hB) begin n_err++; $display("FAIL dual_second got v=%b %h/%h want 1 104/b", mv, maddr, mdata); end
    step();
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL dual_empty mem_req_valid got %b want 0", mv); end
  endtask

  task automatic test_overflow();
    logic [3:0] af_exp;
    af_exp = 4'b1100;  // almost_full after 1st..4th store
    mrdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra = mk(1, 1, 0, 1, 0, 32'h300 + 32'(i * 4), 32'(i + 1));
      step();
      n_cmp++; if (af !== af_exp[i]) begin n_err++; $display("FAIL almost_full_%0d got %b want %b", i, af, af_exp[i]); end
    end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_before got %b want 0", ovf); end
    ra = mk(1, 1, 0, 1, 0, 32'h3FC, 32'hEE);
    step();
    ra = '0;
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", ovf); end
    mrdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mv !== 1'b1 || maddr !== 32'h300 + 32'(i * 4) || mdata !== 32'(i + 1)) begin
        n_err++; $display("FAIL ovf_drain_%0d got v=%b %h/%h want 1 %h/%h", i, mv, maddr, mdata, 32'h300 + 32'(i * 4), i + 1);
      end
      step();
    end
    n_cmp++; if (mv !== 1'b0 || af !== 1'b0) begin n_err++; $display("FAIL ovf_empty got v=%b af=%b want 0/0", mv, af); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    mrdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra = mk(1, 1, 0, 1, 0, 32'h200 + 32'(i * 4), 32'h20 + 32'(i));
      step();
    end
    // Full queue: pop head and push one store on the same edge.
    mrdy = 1'b1;
    ra = mk(1, 1, 0, 1, 0, 32'h210, 32'h24);
    step();
    ra = '0;
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL full_pp_ovf got %b want 0", ovf); end
    n_cmp++; if (af !== 1'b1) begin n_err++; $display("FAIL full_pp_af got %b want 1", af); end
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (mv !== 1'b1 || maddr !== 32'h200 + 32'(i * 4) || mdata !== 32'h20 + 32'(i)) begin
        n_err++; $display("FAIL full_pp_drain_%0d got v=%b %h/%h want 1 %h/%h", i, mv, maddr, mdata, 32'h200 + 32'(i * 4), 32'h20 + 32'(i));
      end
      step();
    end
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL full_pp_empty got %b want 0", mv); end
  endtask

  task automatic test_perf();
    logic [31:0] exp_r, exp_s;
`ifdef RETIRE_PERF_EN
    exp_r = 32'd6; exp_s = 32'd2;
`else
    exp_r = 32'd0; exp_s = 32'd0;
`endif
    do_reset();
    mrdy = 1'b0;
    ra = mk(1, 1, 1, 0, 6'd1, 0, 0); rb = mk(1, 1, 1, 0, 6'd2, 0, 0);
    step(); step();
    ra = mk(1, 1, 0, 1, 0, 32'h400, 32'h4); rb = mk(1, 1, 1, 0, 6'd3, 0, 0);
    step();
    ra = '0; rb = '0;
    step(); step();  // two stalled cycles
    mrdy = 1'b1;
    step();          // accepted, so not a stall
    n_cmp++; if (rcnt !== exp_r) begin n_err++; $display("FAIL retired_cnt got %0d want %0d", rcnt, exp_r); end
    n_cmp++; if (scnt !== exp_s) begin n_err++; $display("FAIL sq_stall_cnt got %0d want %0d", scnt, exp_s); end
    n_cmp++; if (mv !== 1'b0) begin n_err++; $display("FAIL perf_drain got %b want 0", mv); end
  endtask

  initial begin
    reset = 1'b0; ra = '0; rb = '0; mrdy = 1'b0;
    test_reset();
    test_free_list();
    test_dual_store();
    test_overflow();
    test_full_push_pop();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
